// File: rtl/rr_pick.sv
// Purpose: find-first request picker, cyclic from a start index or fixed from index 0.
// Latency: purely combinational.
// Backpressure: none; a pure function of req/start/prio.
//
// Ports:
//   req   - one request bit per channel.
//   start - first index examined in cyclic mode.
//   prio  - 1 = always scan from index 0, so the lowest requester wins.
//   found - at least one request is set.
//   index - chosen channel; 0 when nothing is found.
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    start,
  input  logic                prio,
  output logic                found,
  output logic [SEL_W-1:0]    index
);

  // Two back-to-back copies of req. A linear scan of CHANNELS bits from
  // 'base' then covers the cyclic order base..CHANNELS-1, 0..base-1 with no
  // modulo arithmetic.
  logic [2*CHANNELS-1:0] dbl;
  int                    base;

  always_comb begin
    dbl   = {req, req};
    found = 1'b0;
    index = '0;
    // Out-of-range start values (only possible for non-power-of-2 counts)
    // fall back to 0.
    base  = (prio || (int'(start) >= CHANNELS)) ? 0 : int'(start);
    // Scan from the far end so the nearest hit is the last one written.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (dbl[base + k]) begin
        found = 1'b1;
        index = (base + k >= CHANNELS) ? SEL_W'(base + k - CHANNELS) : SEL_W'(base + k);
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// Purpose: N-channel arbitrating stream mux (round-robin or fixed priority) with burst locking.
// Latency: 1 cycle from input accept to out_valid; sustains 1 beat/cycle.
// Backpressure: in_ready is held low while the output register is full and not being drained.
//
// Ports:
//   clock, reset - rising-edge clock; synchronous active-high reset.
//   mode_prio    - 0 = round-robin, 1 = fixed priority (lowest index wins).
//   in_data      - flattened inputs; channel i is in_data[i*WIDTH +: WIDTH].
//   in_valid     - one valid bit per channel.
//   in_last      - one end-of-burst bit per channel, qualified by in_valid.
//   in_ready     - one-hot (or zero) ready back to the granted channel.
//   out_data     - registered data of the accepted beat.
//   out_sel      - index of the channel that produced out_data.
//   out_last     - registered in_last of the accepted beat.
//   out_valid    - the output register holds a beat.
//   out_ready    - downstream takes the beat.
module stream_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode_prio,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  logic             state, state_d;
  logic [SEL_W-1:0] lock_ch, lock_ch_d;
  logic [SEL_W-1:0] ptr, ptr_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic             space;
  logic             accept;
  logic [WIDTH-1:0] grant_data;
  logic             grant_last;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .req   (in_valid),
    .start (ptr),
    .prio  (mode_prio),
    .found (pick_found),
    .index (pick_idx)
  );

  assign space = !out_valid || out_ready;

  // While locked the grant ignores every in_valid, so in_ready never loops
  // back through the granted channel's own valid.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (state == STATE_LOCKED) begin
      grant_vld = 1'b1;
      grant     = lock_ch;
    end else begin
      grant_vld = pick_found;
      grant     = pick_idx;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = grant_vld && (grant == SEL_W'(i)) && space && !reset;
    end
  end

  assign accept     = grant_vld && space && !reset && in_valid[grant];
  assign grant_data = in_data[int'(grant)*WIDTH +: WIDTH];
  assign grant_last = in_last[grant];

  // Next-state: a non-last beat locks onto its channel; a last beat
  // releases the lock and, in round-robin mode, moves the pointer past the
  // winner with an explicit wrap for non-power-of-2 channel counts.
  always_comb begin
    state_d   = state;
    lock_ch_d = lock_ch;
    ptr_d     = ptr;
    if (accept) begin
      if (!grant_last) begin
        state_d   = STATE_LOCKED;
        lock_ch_d = grant;
      end else begin
        state_d = STATE_IDLE;
        if (!mode_prio) begin
          ptr_d = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= STATE_IDLE;
      lock_ch   <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else begin
      state   <= state_d;
      lock_ch <= lock_ch_d;
      ptr     <= ptr_d;
      if (accept) begin
        // A pop and a load in the same cycle keep out_valid high.
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        out_last  <= grant_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
module tb_stream_arb_mux;

  logic         clock = 1'b0;
  logic         reset;
  logic         mode_prio;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_last;
  logic         out_ready;

  logic [3:0]   rdy4;
  logic [31:0]  od4;
  logic [1:0]   os4;
  logic         ol4, ov4;
  logic [2:0]   rdy3;
  logic [31:0]  od3;
  logic [1:0]   os3;
  logic         ol3, ov3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  stream_arb_mux #(.WIDTH(32), .CHANNELS(4)) dut4 (
    .clock(clock), .reset(reset), .mode_prio(mode_prio),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy4), .out_data(od4), .out_sel(os4), .out_last(ol4),
    .out_valid(ov4), .out_ready(out_ready)
  );

  stream_arb_mux #(.WIDTH(32), .CHANNELS(3)) dut3 (
    .clock(clock), .reset(reset), .mode_prio(mode_prio),
    .in_data(in_data[95:0]), .in_valid(in_valid[2:0]), .in_last(in_last[2:0]),
    .in_ready(rdy3), .out_data(od3), .out_sel(os3), .out_last(ol3),
    .out_valid(ov3), .out_ready(out_ready)
  );

  // Reference model, index 0 = 4-channel DUT, 1 = 3-channel DUT.
  bit          m_lk  [2];
  int          m_lch [2];
  int          m_ptr [2];
  bit          m_ov  [2];
  logic [31:0] m_od  [2];
  int          m_os  [2];
  bit          m_ol  [2];

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d ? 3 : 4, obs, exp);
    end
  endtask

  // Who the arbitration rules say may send this cycle; -1 if nobody.
  function automatic int mgrant(input int d);
    int n;
    n = d ? 3 : 4;
    if (m_lk[d]) return m_lch[d];
    for (int k = 0; k < n; k++) begin
      int i;
      i = mode_prio ? k : (m_ptr[d] + k) % n;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lk[d] = 0; m_lch[d] = 0; m_ptr[d] = 0;
      m_ov[d] = 0; m_od[d] = '0; m_os[d] = 0; m_ol[d] = 0;
    end
  endtask

  // One clock: check in_ready before the edge, advance the model across
  // the edge, then check the registered outputs.
  task automatic step();
    int  g   [2];
    bit  sp  [2];
    int  n;
    logic [3:0] exp_rdy;
    #2;
    for (int d = 0; d < 2; d++) begin
      g[d]  = mgrant(d);
      sp[d] = !m_ov[d] || out_ready;
      exp_rdy = (g[d] >= 0 && sp[d] && !reset) ? (4'b1 << g[d]) : 4'b0;
      if (d == 0) chk("in_ready", 0, 64'(rdy4), 64'(exp_rdy));
      else        chk("in_ready", 1, 64'(rdy3), 64'(exp_rdy[2:0]));
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      n = d ? 3 : 4;
      if (reset) begin
        m_lk[d] = 0; m_lch[d] = 0; m_ptr[d] = 0;
        m_ov[d] = 0; m_od[d] = '0; m_os[d] = 0; m_ol[d] = 0;
      end else if (g[d] >= 0 && sp[d] && in_valid[g[d]]) begin
        m_ov[d] = 1;
        m_od[d] = in_data[g[d]*32 +: 32];
        m_os[d] = g[d];
        m_ol[d] = in_last[g[d]];
        if (!in_last[g[d]]) begin
          m_lk[d] = 1; m_lch[d] = g[d];
        end else begin
          m_lk[d] = 0;
          if (!mode_prio) m_ptr[d] = (g[d] + 1) % n;
        end
      end else if (out_ready) begin
        m_ov[d] = 0;
      end
    end
    #1;
    chk("out_valid", 0, 64'(ov4), 64'(m_ov[0]));
    chk("out_data",  0, 64'(od4), 64'(m_od[0]));
    chk("out_sel",   0, 64'(os4), 64'(m_os[0]));
    chk("out_last",  0, 64'(ol4), 64'(m_ol[0]));
    chk("out_valid", 1, 64'(ov3), 64'(m_ov[1]));
    chk("out_data",  1, 64'(od3), 64'(m_od[1]));
    chk("out_sel",   1, 64'(os3), 64'(m_os[1]));
    chk("out_last",  1, 64'(ol3), 64'(m_ol[1]));
  endtask

  task automatic tag_data(input logic [7:0] stamp);
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = {8'hC0 + 8'(i), 16'h0, stamp};
  endtask

  initial begin
    int seq4 [6];
    int seq3 [6];
    seq4 = '{0, 1, 2, 3, 0, 1};
    seq3 = '{0, 1, 2, 0, 1, 2};
    model_reset();

    // Reset with every channel requesting.
    reset = 1; mode_prio = 0; in_valid = 4'hF; in_last = 4'hF; out_ready = 1;
    tag_data(8'h00);
    step();
    step();
    chk("reset_out_data", 0, 64'(od4), 64'h0);

    // Round-robin, single-beat packets; first grant after reset is ch0.
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      tag_data(8'(k + 1));
      step();
      chk("rr_seq", 0, 64'(os4), 64'(seq4[k]));
      chk("rr_seq", 1, 64'(os3), 64'(seq3[k]));
      chk("rr_full_rate", 0, 64'(ov4), 64'h1);
    end

    // Fixed priority: ch1 always wins over 2 and 3.
    mode_prio = 1; in_valid = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      tag_data(8'(k + 16));
      step();
      chk("prio_sel", 0, 64'(os4), 64'h1);
    end

    // Burst lock on ch2 (reached via a lone request), ch0/ch1 also pending.
    mode_prio = 0; in_valid = 4'b0100; in_last = 4'b1011;
    tag_data(8'h30);
    step();
    in_valid = 4'b0111;
    tag_data(8'h31);
    step();
    chk("lock_sel", 0, 64'(os4), 64'h2);
    in_last = 4'b1111;
    tag_data(8'h32);
    step();
    chk("lock_sel", 0, 64'(os4), 64'h2);
    chk("lock_last", 0, 64'(ol4), 64'h1);
    // ch3 idle: pointer at 3 wraps to 0.
    tag_data(8'h33);
    step();
    chk("lock_next", 0, 64'(os4), 64'h0);

    // Backpressure on a ch1 beat.
    in_valid = 4'b0010; in_last = 4'hF;
    in_data[32 +: 32] = 32'hDEADBEEF;
    step();
    out_ready = 0;
    in_data[32 +: 32] = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_data", 0, 64'(od4), 64'hDEADBEEF);
      chk("bp_sel", 0, 64'(os4), 64'h1);
      chk("bp_rdy", 0, 64'(rdy4), 64'h0);
    end
    out_ready = 1;
    step();
    chk("bp_release", 0, 64'(od4), 64'h12345678);
    chk("bp_nobubble", 0, 64'(ov4), 64'h1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) mode_prio = ~mode_prio;
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom) | 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Parametrised N-channel arbitrating multiplexer with valid/ready handshakes and a registered output stage.
- Successor to the combinational mux_2/mux4 family: the select is generated internally by the arbiter rather than supplied.
- Serves the midisynth path, where multiple voice/event sources share one downstream consumer (mixer, MMIO FIFO).
- Arbitration is round-robin or fixed-priority; bursts can be locked so a packet is never interleaved with another channel's beats.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of input channels (≥2, need not be a power of 2).
- SEL_W, $clog2(CHANNELS), width of the channel index.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mode_prio  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_last  in  CHANNELS  per-channel end-of-burst marker, qualified by in_valid.
- in_ready  out  CHANNELS  per-channel ready (one-hot or zero).
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  index of the channel that produced out_data.
- out_last  out  1  registered copy of the accepted beat's in_last.
- out_valid  out  1  output holds a beat.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - RR pointer=0, state=IDLE.
  - in_ready=0 while reset is high.
  - Reset mid-burst drops the lock and any held beat.
- Output stage capacity: space = !out_valid | out_ready.
- Grant (combinational, from the current state only):
  - IDLE, mode_prio=0: lowest i in cyclic order ptr, ptr+1, …, CHANNELS-1, 0, … with in_valid[i].
  - IDLE, mode_prio=1: lowest i with in_valid[i].
  - LOCKED: grant = lock_ch, regardless of the other channels' valids.
  - No candidate: no grant, in_ready=0.
- Ready and accept:
  - in_ready[i] = (grant==i) & space.
  - Accept = in_valid[g] & in_ready[g].
  - in_ready must not depend on in_valid of the granted channel in LOCKED state, so there is no combinational loop.
- On accept, at the next edge:
  - out_data<=in_data[g], out_sel<=g, out_last<=in_last[g], out_valid<=1.
  - If in_last[g]=0: state<=LOCKED, lock_ch<=g.
  - If in_last[g]=1: state<=IDLE.
  - RR mode: ptr<=(g==CHANNELS-1)?0:g+1, updated only when in_last[g]=1 (burst end), so ptr wraps explicitly for non-power-of-2 counts.
  - Priority mode: ptr is unchanged.
- Output handshake:
  - out_valid & out_ready with no accept: out_valid<=0, data registers hold.
  - out_valid & !out_ready: out_data/out_sel/out_last stable and in_ready all 0 (backpressure).
- Latency and throughput:
  - Latency is 1 cycle, in-accept to out_valid.
  - Sustained 1 beat/cycle when out_ready=1.
- LOCKED with in_valid[lock_ch]=0:
  - Bubble; the lock is held indefinitely and other channels starve by design.
- Changing mode_prio:
  - Takes effect at the next IDLE arbitration.
  - Never breaks an active lock.
- Single-beat packets: in_last=1 on every beat gives per-beat arbitration.
- Simultaneous events: a downstream pop and an upstream accept in the same cycle produce no bubble; out_valid stays 1 and the new beat is loaded.

Decomposition:
- No package needed.
- SEL_W is a parameter derived by $clog2.
- State encoding as localparams STATE_IDLE=1'b0, STATE_LOCKED=1'b1, local to the block.
- One combinational sub-module: rr_pick #(CHANNELS, SEL_W).
  - Inputs: req vector, start pointer, prio flag.
  - Outputs: found and index.
  - Implemented as a doubled-vector find-first scan.
  - Reusable by later arbiters.

Test Plan:
- Reset: hold reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 during reset; first grant after release goes to channel 0.
- Round-robin fairness: CHANNELS=4, mode_prio=0, all in_valid=1, in_last=1, out_ready=1 -> out_sel sequence 0,1,2,3,0,1; out_valid=1 every cycle from cycle 1.
- Fixed priority: mode_prio=1, in_valid=4'b1110 constant -> out_sel=1 on every beat; channels 2 and 3 never get in_ready.
- Burst lock: ch2 sends 3 beats with in_last=0,0,1 while ch0/ch1 valid -> out_sel=2,2,2 contiguously, out_last=0,0,1; the next grant goes to ch3, wrapping to 0 if ch3 is idle.
- Backpressure: out_ready=0 for 3 cycles after a beat of data 32'hDEADBEEF from ch1 -> out_data/out_sel stable at DEADBEEF/1 and in_ready=0; on out_ready=1 the next beat loads with no bubble.
- Non-power-of-2 wrap: CHANNELS=3, all valid, RR -> out_sel 0,1,2,0,1,2; ptr never reaches 3.
